// File: rtl/pe_array_sequencer.sv
// pe_array_sequencer: initiator side of the pe_array command/ready/ack handshake.
// Host step commands are buffered in a small FIFO. Each command is issued to the
// array max(repeat,1) times, and every issue is closed with a one-cycle array_ack.
// Optional feature: define PE_SEQ_TIMEOUT_EN to enable the WAIT/RELEASE watchdog
// and the sticky timeout_err flag.
module pe_array_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned REPEAT_W       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [1:0]          cmd_dir,
    input  logic [REPEAT_W-1:0] cmd_repeat,
    output logic [2:0]          command_to_execute,
    output logic [1:0]          shift_direction,
    input  logic                array_ready,
    output logic                array_ack,
    output logic                busy,
    output logic                step_done,
    output logic                cmd_done,
    output logic [15:0]         step_count,
    output logic                timeout_err
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 3 + 2 + REPEAT_W;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_t;

    state_t state_q, state_d;

    logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       fifo_cnt;
    logic                fifo_empty, fifo_full;
    logic                push, pop, flush;
    logic [2:0]          head_op;
    logic [1:0]          head_dir;
    logic [REPEAT_W-1:0] head_rep;

    logic [2:0]          op_q;
    logic [1:0]          dir_q;
    logic [REPEAT_W-1:0] remaining_q;
    logic                load, dec;

`ifdef PE_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt;
    logic          wd_expired;
`endif

    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == DEPTH_C);
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && !fifo_full;
    assign {head_op, head_dir, head_rep} = fifo_mem[rd_ptr];
    assign busy       = !fifo_empty || (state_q != S_IDLE);

    // FIFO storage; the head entry is read combinationally (first-word-fall-through)
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {cmd_op, cmd_dir, cmd_repeat};
        end
    end

    // FIFO pointers and occupancy; reset and watchdog flush both empty it
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Working command registers and the completed-issue counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_q        <= '0;
            dir_q       <= '0;
            remaining_q <= '0;
            step_count  <= '0;
        end else begin
            if (load) begin
                op_q        <= head_op;
                dir_q       <= head_dir;
                remaining_q <= (head_rep == '0) ? REPEAT_W'(1) : head_rep;
            end else if (dec) begin
                remaining_q <= remaining_q - 1'b1;
            end
            if (dec) step_count <= step_count + 16'd1;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_d            = state_q;
        pop                = 1'b0;
        load               = 1'b0;
        dec                = 1'b0;
        flush              = 1'b0;
        command_to_execute = '0;
        shift_direction    = '0;
        array_ack          = 1'b0;
        step_done          = 1'b0;
        cmd_done           = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                    // NOP entries are retired on the spot without touching the array
                    if (head_op == 3'b000) begin
                        cmd_done = 1'b1;
                    end else begin
                        load    = 1'b1;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                command_to_execute = op_q;
                shift_direction    = dir_q;
                state_d            = S_WAIT;
            end
            S_WAIT: begin
                command_to_execute = op_q;
                shift_direction    = dir_q;
                if (array_ready) state_d = S_ACK;
            end
            S_ACK: begin
                command_to_execute = op_q;
                shift_direction    = dir_q;
                array_ack          = 1'b1;
                step_done          = 1'b1;
                dec                = 1'b1;
                state_d            = S_RELEASE;
            end
            S_RELEASE: begin
                if (!array_ready) begin
                    if (remaining_q != '0) begin
                        state_d = S_ISSUE;
                    end else begin
                        cmd_done = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef PE_SEQ_TIMEOUT_EN
        // Watchdog expiry overrides the handshake: abandon command and queue silently
        if (wd_expired) begin
            state_d            = S_IDLE;
            flush              = 1'b1;
            cmd_done           = 1'b0;
            command_to_execute = '0;
            shift_direction    = '0;
        end
`endif
    end

`ifdef PE_SEQ_TIMEOUT_EN
    assign wd_expired = ((state_q == S_WAIT) || (state_q == S_RELEASE)) &&
                        (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog: counts cycles spent in WAIT/RELEASE, restarts on every state change
    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_d != state_q) begin
                wd_cnt <= '0;
            end else if ((state_q == S_WAIT) || (state_q == S_RELEASE)) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expired) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
